// File: rtl/log_mul_pkg.sv
// log_mul_pkg: shared constants, encodings and the stage-1 record for the log-domain multiplier
package log_mul_pkg;
  localparam int LM = 3;
  localparam int LF = 4;
  function automatic int BIAS(input int m, input int f);
    return 1 << (m - 1 + f);
  endfunction
  function automatic int MAXU(input int m, input int f);
    return (1 << (m + f)) - 2;
  endfunction
  function automatic int ZERO(input int m, input int f);
    return (1 << (m + f)) - 1;
  endfunction
  function automatic int INF(input int m, input int f);
    return (1 << (m + f + 1)) - 1;
  endfunction
  typedef struct packed {
    logic sign;
    logic signed [LM+LF+1:0] sum;
    logic is_za;
    logic is_zb;
    logic is_inf_a;
    logic is_inf_b;
  } stage1_t;
endpackage

// File: rtl/log_mul_encode.sv
// log_mul_encode: stage-2 classify/saturate of a stage-1 record into the output code.
// Status flags exist only when LOG_MUL_STATUS_EN is defined.
module log_mul_encode
  import log_mul_pkg::*;
#(
  parameter int M = LM,
  parameter int F = LF
) (
  input  stage1_t      s1,
  output logic [M+F:0] y
`ifdef LOG_MUL_STATUS_EN
  ,
  output logic         ovf,
  output logic         unf
`endif
);
  localparam int W = M + F;
  localparam logic [W:0] zero_c = (W+1)'(ZERO(M, F));
  localparam logic [W:0] inf_c = (W+1)'(INF(M, F));
  localparam logic [W-1:0] maxu_c = W'(MAXU(M, F));
  logic any_inf, any_zero, neg, big;
  always_comb begin
    any_inf = s1.is_inf_a || s1.is_inf_b;
    any_zero = s1.is_za || s1.is_zb;
    neg = s1.sum[W+1];
    big = !neg && (s1.sum > $signed({2'b00, maxu_c}));
    // INF dominates ZERO, so ZERO*INF yields INF
    y = any_inf ? inf_c :
        (any_zero || neg) ? zero_c :
        big ? {s1.sign, maxu_c} : {s1.sign, s1.sum[W-1:0]};
  end
`ifdef LOG_MUL_STATUS_EN
  assign ovf = !any_inf && !any_zero && big;
  assign unf = !any_inf && !any_zero && neg;
`endif
endmodule

// File: rtl/log_mul_pipe.sv
// log_mul_pipe: two-stage valid/ready log-domain multiplier (add biased logs, xor signs).
// Define LOG_MUL_STATUS_EN for overflow/underflow flags and sticky status outputs.
module log_mul_pipe
  import log_mul_pkg::*;
#(
  parameter int M = LM,
  parameter int F = LF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inValid,
  output logic         inReady,
  input  logic [M+F:0] inA,
  input  logic [M+F:0] inB,
  output logic         outValid,
  input  logic         outReady,
  output logic [M+F:0] out
`ifdef LOG_MUL_STATUS_EN
  ,
  output logic         outOverflow,
  output logic         outUnderflow,
  output logic         stickyOverflow,
  output logic         stickyUnderflow
`endif
);
  localparam int W = M + F;
  localparam logic [W:0] zero_c = (W+1)'(ZERO(M, F));
  localparam logic [W:0] inf_c = (W+1)'(INF(M, F));
  localparam logic signed [W+1:0] bias_c = (W+2)'(BIAS(M, F));
  logic v1_q, v1_d, v2_q, v2_d, adv1, adv2;
  stage1_t s1_q, s1_d, s1_n;
  logic [W:0] out_q, out_d, enc;
`ifdef LOG_MUL_STATUS_EN
  logic ovf_q, ovf_d, unf_q, unf_d, sov_q, sov_d, sun_q, sun_d, enc_ovf, enc_unf;
`endif
  always_comb begin
    adv2 = !v2_q || outReady;
    adv1 = !v1_q || adv2;
    v1_d = adv1 ? inValid : v1_q;
    v2_d = adv2 ? v1_q : v2_q;
    s1_n.sign = inA[W] ^ inB[W];
    s1_n.sum = $signed({2'b00, inA[W-1:0]}) + $signed({2'b00, inB[W-1:0]}) - bias_c;
    s1_n.is_za = inA == zero_c;
    s1_n.is_zb = inB == zero_c;
    s1_n.is_inf_a = inA == inf_c;
    s1_n.is_inf_b = inB == inf_c;
    s1_d = (adv1 && inValid) ? s1_n : s1_q;
    out_d = (adv2 && v1_q) ? enc : out_q;
  end
  log_mul_encode #(.M(M), .F(F)) u_enc (
    .s1 (s1_q),
    .y  (enc)
`ifdef LOG_MUL_STATUS_EN
    ,
    .ovf(enc_ovf),
    .unf(enc_unf)
`endif
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
      out_q <= zero_c;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      s1_q <= s1_d;
      out_q <= out_d;
    end
  end
  assign inReady = adv1;
  assign outValid = v2_q;
  assign out = out_q;
`ifdef LOG_MUL_STATUS_EN
  always_comb begin
    ovf_d = (adv2 && v1_q) ? enc_ovf : ovf_q;
    unf_d = (adv2 && v1_q) ? enc_unf : unf_q;
    sov_d = sov_q || (v2_q && outReady && ovf_q);
    sun_d = sun_q || (v2_q && outReady && unf_q);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      sov_q <= 1'b0;
      sun_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      sov_q <= sov_d;
      sun_q <= sun_d;
    end
  end
  assign outOverflow = ovf_q;
  assign outUnderflow = unf_q;
  assign stickyOverflow = sov_q;
  assign stickyUnderflow = sun_q;
`endif
endmodule

// File: tb/tb_log_mul_pipe.sv
// tb_log_mul_pipe: directed and randomized checks of log_mul_pipe against a queue-based reference model
module tb_log_mul_pipe;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic inValid = 1'b0;
  logic outReady = 1'b0;
  logic [7:0] inA = 8'h00;
  logic [7:0] inB = 8'h00;
  logic inReady, outValid;
  logic [7:0] out;
`ifdef LOG_MUL_STATUS_EN
  logic outOverflow, outUnderflow, stickyOverflow, stickyUnderflow;
`endif
  int checks = 0;
  int failures = 0;
  int n_in = 0;
  int n_out = 0;
  logic [9:0] sb[$];

  log_mul_pipe dut (
    .clock   (clock),
    .reset   (reset),
    .inValid (inValid),
    .inReady (inReady),
    .inA     (inA),
    .inB     (inB),
    .outValid(outValid),
    .outReady(outReady),
    .out     (out)
`ifdef LOG_MUL_STATUS_EN
    ,
    .outOverflow    (outOverflow),
    .outUnderflow   (outUnderflow),
    .stickyOverflow (stickyOverflow),
    .stickyUnderflow(stickyUnderflow)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: value-level rules for M=3, F=4 (bias 64, max code 126); returns {ovf, unf, code}
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b);
    int s;
    logic sg;
    s = int'(a[6:0]) + int'(b[6:0]) - 64;
    sg = a[7] ^ b[7];
    if (a == 8'hFF || b == 8'hFF) return {2'b00, 8'hFF};
    if (a == 8'h7F || b == 8'h7F) return {2'b00, 8'h7F};
    if (s < 0) return {2'b01, 8'h7F};
    if (s > 126) return {2'b10, sg, 7'd126};
    return {2'b00, sg, 7'(s)};
  endfunction

  function automatic logic [7:0] pick();
    int r;
    r = int'($urandom_range(0, 7));
    return r == 0 ? 8'h7F : r == 1 ? 8'hFF : 8'($urandom);
  endfunction

  task automatic tick();
    logic [9:0] e;
    #1;
    if (!reset) check("in_ready", inReady, 32'(sb.size() < 2 || outReady));
    if (!reset && outValid && outReady) begin
      n_out++;
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out", out, e[7:0]);
`ifdef LOG_MUL_STATUS_EN
        check("out_ovf", outOverflow, e[9]);
        check("out_unf", outUnderflow, e[8]);
`endif
      end
    end
    if (!reset && inValid && inReady) begin
      n_in++;
      sb.push_back(model(inA, inB));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic single(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                        input logic ov, input logic un);
    check("model_direct", model(a, b), {ov, un, exp});
    inA = a;
    inB = b;
    inValid = 1'b1;
    outReady = 1'b1;
    tick();
    inValid = 1'b0;
    check("lat1_valid", outValid, 0);
    tick();
    check("lat2_valid", outValid, 1);
    check("direct_out", out, exp);
`ifdef LOG_MUL_STATUS_EN
    check("direct_ovf", outOverflow, ov);
    check("direct_unf", outUnderflow, un);
`endif
    tick();
  endtask

  initial begin
    int n0;
    logic [7:0] held;
    logic have;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", outValid, 0);
    check("rst_out", out, 8'h7F);
    check("rst_ready", inReady, 1);
`ifdef LOG_MUL_STATUS_EN
    check("rst_sticky_ov", stickyOverflow, 0);
    check("rst_sticky_un", stickyUnderflow, 0);
`endif
    single(8'h40, 8'h40, 8'h40, 1'b0, 1'b0);
    single(8'h50, 8'hD0, 8'hE0, 1'b0, 1'b0);
    single(8'h78, 8'h78, 8'h7E, 1'b1, 1'b0);
    single(8'h0A, 8'h0A, 8'h7F, 1'b0, 1'b1);
    single(8'h7F, 8'hFF, 8'hFF, 1'b0, 1'b0);
    single(8'h7F, 8'hC0, 8'h7F, 1'b0, 1'b0);
    single(8'h7F, 8'h7F, 8'h7F, 1'b0, 1'b0);
`ifdef LOG_MUL_STATUS_EN
    check("sticky_ov_set", stickyOverflow, 1);
    check("sticky_un_set", stickyUnderflow, 1);
`endif
    outReady = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      inA = pick();
      inB = pick();
      inValid = 1'b1;
      check("stream_rdy", inReady, 1);
      tick();
    end
    inValid = 1'b0;
    tick();
    tick();
    check("stream_cnt", 32'(n_out - n0), 8);
    outReady = 1'b0;
    n0 = n_in;
    have = 1'b0;
    held = 8'h00;
    for (int i = 0; i < 5; i++) begin
      inA = pick();
      inB = pick();
      inValid = 1'b1;
      tick();
      if (outValid) begin
        if (have) check("stall_hold", out, held);
        held = out;
        have = 1'b1;
      end
    end
    check("stall_acc", 32'(n_in - n0), 2);
    check("stall_rdy", inReady, 0);
    inValid = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("drain_empty", 32'(sb.size()), 0);
    outReady = 1'b0;
    inA = 8'h78;
    inB = 8'h78;
    inValid = 1'b1;
    tick();
    tick();
    tick();
    check("full_before_rst", outValid, 1);
    inValid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check("rst2_valid", outValid, 0);
    check("rst2_out", out, 8'h7F);
    check("rst2_ready", inReady, 1);
`ifdef LOG_MUL_STATUS_EN
    check("rst2_sticky_ov", stickyOverflow, 0);
    check("rst2_sticky_un", stickyUnderflow, 0);
`endif
    for (int i = 0; i < 400; i++) begin
      inValid = ($urandom % 4) != 0;
      outReady = ($urandom % 3) != 0;
      inA = pick();
      inB = pick();
      tick();
    end
    inValid = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("final_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/log_mul_pipe.md
Name: log_mul_pipe

Overview:
- Two-stage pipelined multiplier for log-domain numbers, placed directly downstream of the log-number producers and feeding the log-domain accumulator.
- A product in the log domain is an addition of the biased fixed-point log magnitudes plus an XOR of the signs, with special-value and saturation handling.
- Valid/ready handshake on both sides. Full throughput: one product per cycle when not stalled.

Parameters:
- M, 3, log exponent width in bits.
- F, 4, log fraction width in bits.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- inValid  input  1  operands a/b valid.
- inReady  output  1  block can accept operands this cycle.
- inA  input  M+F+1  operand A, packed {sign, logExp[M-1:0], logFrac[F-1:0]}.
- inB  input  M+F+1  operand B, same layout.
- outValid  output  1  product valid.
- outReady  input  1  downstream accepts the product.
- out  output  M+F+1  product, same layout.

Behaviour:
- Encoding:
  - u = {logExp, logFrac}, unsigned (M+F)-bit; value = (-1)^sign * 2^((u - BIAS)/2^F), where BIAS = 2^(M-1+F).
  - ZERO = {0, all ones}; INF = {1, all ones}; MAXU = 2^(M+F) - 2.
- Transfer: a transfer occurs on a clock edge when valid && ready.
- Stage 1 registers:
  - sA ^ sB.
  - Signed sum s = uA + uB - BIAS, computed at M+F+2 bits with no truncation.
  - Flags isZA, isZB, isInfA, isInfB.
- Stage 2 registers the encoded result. Priority order:
  1. Either operand INF -> INF (this includes ZERO*INF).
  2. Else either operand ZERO -> ZERO.
  3. Else s < 0 -> ZERO (underflow).
  4. Else s > MAXU -> {sign, MAXU} (overflow saturates to the max code; the all-ones code is never produced from arithmetic).
  5. Else {sign, s[M+F-1:0]}.
- ZERO output always has sign 0.
- Latency: exactly 2 cycles from input transfer to outValid with no stalls.
- Flow control:
  - Each stage has its own valid bit. A stage advances when it is empty or its successor accepts.
  - inReady = !v1 || !v2 || outReady (combinational from outReady only; no combinational path from inValid).
  - Data registers hold while stalled. out is stable while outValid && !outReady.
- Simultaneous accept at input and output while both stages are full: both stages shift, no bubble.
- Reset values: v1 = v2 = 0, outValid = 0, out = ZERO, inReady = 1 in the cycle after reset. Data in flight at reset is discarded.

Optional Feature:
- Macro LOG_MUL_STATUS_EN.
- Defined:
  - Adds output outOverflow (1 bit, aligned with out/outValid, set when rule 4 fired).
  - Adds output outUnderflow (1 bit, aligned with out/outValid, set when rule 3 fired).
  - Adds stickyOverflow and stickyUnderflow, which set on output transfer of a flagged result and clear only on reset.
- Undefined: these ports and registers do not exist; datapath behaviour is identical.

Decomposition:
- Package log_mul_pkg holds:
  - Functions BIAS(M, F) and MAXU(M, F).
  - Encode constants for ZERO and INF as functions of M and F.
  - Stage-1 packed struct typedef {sign, sum, isZA, isZB, isInfA, isInfB}.
- One sub-module, log_mul_encode: combinational stage-2 classify/saturate from the stage-1 struct to the output word (plus flags under the macro).

Test Plan (M=3, F=4; BIAS=64, MAXU=126, ZERO=8'h7F, INF=8'hFF):
- 8'h40 * 8'h40 (1*1) with outReady=1 -> out=8'h40 two cycles later; 8'h50 * 8'hD0 (2*-2) -> out=8'hE0.
- 8'h78 * 8'h78 -> s=176 -> out=8'h7E; outOverflow=1 if enabled. 8'h0A * 8'h0A -> s=-44 -> out=8'h7F; outUnderflow=1.
- 8'h7F * 8'hFF -> 8'hFF. 8'h7F * 8'hC0 -> 8'h7F (sign 0). 8'h7F * 8'h7F -> 8'h7F.
- Stream 8 back-to-back pairs, outReady=1 -> 8 results on consecutive cycles, order preserved, inReady never low.
- Fill the pipe, hold outReady=0 for 5 cycles -> inReady=0 after 2 accepts, out stable; release -> no loss or duplication.
- Assert reset with both stages full -> next cycle outValid=0, out=8'h7F, inReady=1; sticky flags cleared.
